// File: rtl/semaforo_ctrl.sv
// Traffic-light controller: RED->GREEN->YELLOW cycle timed by tick, with a 7-segment countdown.
// Define SEMAFORO_PED_REQ_EN to compile in the pedestrian request that shortens GREEN.
module semaforo_ctrl #(
  parameter int unsigned RED_T   = 7,
  parameter int unsigned GRN_T   = 7,
  parameter int unsigned YEL_T   = 2,
  parameter int unsigned PED_MIN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       ped_req,
  output logic [2:0] lamp,
  output logic [3:0] digit,
  output logic [6:0] seg7,
  output logic       phase_done
);

  localparam int unsigned DW = 4;
  localparam int unsigned LW = 3;
  localparam int unsigned SW = 7;

  localparam logic [LW-1:0] LAMP_RED = 3'b100;
  localparam logic [LW-1:0] LAMP_GRN = 3'b001;
  localparam logic [LW-1:0] LAMP_YEL = 3'b010;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] digit_nxt;
  logic [LW-1:0] lamp_nxt;
  logic          phase_done_nxt;

`ifdef SEMAFORO_PED_REQ_EN
  logic ped_pend, ped_pend_nxt;
`else
  logic ped_unused;
  assign ped_unused = ped_req;
`endif

  // Phase duration loaded when a phase is entered.
  function automatic logic [DW-1:0] dur_of(input state_t s);
    case (s)
      ST_GREEN:  dur_of = DW'(GRN_T);
      ST_YELLOW: dur_of = DW'(YEL_T);
      default:   dur_of = DW'(RED_T);
    endcase
  endfunction

  function automatic logic [LW-1:0] lamp_of(input state_t s);
    case (s)
      ST_GREEN:  lamp_of = LAMP_GRN;
      ST_YELLOW: lamp_of = LAMP_YEL;
      default:   lamp_of = LAMP_RED;
    endcase
  endfunction

  // State, countdown and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RED;
      digit      <= DW'(RED_T);
      lamp       <= LAMP_RED;
      phase_done <= 1'b0;
`ifdef SEMAFORO_PED_REQ_EN
      ped_pend   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      digit      <= digit_nxt;
      lamp       <= lamp_nxt;
      phase_done <= phase_done_nxt;
`ifdef SEMAFORO_PED_REQ_EN
      ped_pend   <= ped_pend_nxt;
`endif
    end
  end

  // Next-state, countdown and pedestrian shortening.
  always_comb begin
    state_nxt      = state;
    digit_nxt      = digit;
    phase_done_nxt = 1'b0;
`ifdef SEMAFORO_PED_REQ_EN
    ped_pend_nxt   = ped_pend | ped_req;
`endif

    if (tick && (digit == DW'(1))) begin
      case (state)
        ST_RED:   state_nxt = ST_GREEN;
        ST_GREEN: state_nxt = ST_YELLOW;
        default:  state_nxt = ST_RED;
      endcase
      digit_nxt      = dur_of(state_nxt);
      phase_done_nxt = 1'b1;
`ifdef SEMAFORO_PED_REQ_EN
      if (state_nxt == ST_YELLOW) begin
        ped_pend_nxt = 1'b0;
      end
      if ((state_nxt == ST_GREEN) && ped_pend) begin
        digit_nxt = DW'(PED_MIN);
      end
`endif
    end else begin
      if (tick) begin
        digit_nxt = digit - DW'(1);
      end
`ifdef SEMAFORO_PED_REQ_EN
      // A pending request cuts GREEN down to PED_MIN but never extends it.
      if ((state == ST_GREEN) && (ped_pend || ped_req) && (digit > DW'(PED_MIN))) begin
        digit_nxt = DW'(PED_MIN);
      end
`endif
    end

    lamp_nxt = lamp_of(state_nxt);
  end

  // Segment decode abcdefg, blank above 9.
  always_comb begin
    seg7 = SW'(0);
    case (digit)
      4'd0:    seg7 = 7'b1111110;
      4'd1:    seg7 = 7'b0110000;
      4'd2:    seg7 = 7'b1101101;
      4'd3:    seg7 = 7'b1111001;
      4'd4:    seg7 = 7'b0110011;
      4'd5:    seg7 = 7'b1011011;
      4'd6:    seg7 = 7'b1011111;
      4'd7:    seg7 = 7'b1110000;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1111011;
      default: seg7 = 7'b0000000;
    endcase
  end

endmodule
